blk_6ef2cf: RTL and testbench



---
 rtl/dragonfang_pkg.sv | 21 ++
 rtl/riscv_v_pkg.sv | 14 +
 rtl/vector_writeback_fifo.sv | 79 +++++++
 rtl/blk_6ef2cf.sv | 103 ++++++++++
 tb/tb_blk_6ef2cf.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/dragonfang_pkg.sv
// ============================================================
// Package : dragonfang_pkg
// Brief   : Writeback entry type and vd address width.
// Revision: 1.0
// ============================================================
`default_nettype none

package dragonfang_pkg;

  import riscv_v_pkg::*;

  localparam int VD_ADDR_W = 5;

  typedef struct packed {
    logic [VD_ADDR_W-1:0] vd_address;
    logic [VLEN-1:0]      data;
  } wb_entry_t;

endpackage : dragonfang_pkg

`default_nettype wire

// File: rtl/riscv_v_pkg.sv
// ============================================================
// Package : riscv_v_pkg
// Brief   : Vector ISA constants shared across the vector unit.
// Revision: 1.0
// ============================================================
`default_nettype none

package riscv_v_pkg;

  localparam int VLEN = 128;

endpackage : riscv_v_pkg

`default_nettype wire

// File: rtl/vector_writeback_fifo.sv
// ============================================================
// Module  : vector_writeback_fifo
// Brief   : DEPTH x wb_entry_t synchronous FIFO, first-word fall-through.
// Revision: 1.0
// ============================================================
`default_nettype none

module vector_writeback_fifo
  import dragonfang_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic                   push,
  input  wb_entry_t              push_entry,
  input  logic                   pop,
  output logic                   head_valid,
  output wb_entry_t              head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = $clog2(DEPTH) + 1;
  localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

  wb_entry_t          r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;

  always_ff @(posedge clock) begin
    if (!reset_n || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end
      if (pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; stale slots are hidden by the zero-count mask below.
  always_ff @(posedge clock) begin
    if (push && reset_n && !flush) begin
      r_mem[r_wr_ptr] <= push_entry;
    end
  end

  always_comb begin
    head_valid = (r_count != '0);
    head       = '0;
    if (head_valid) begin
      head = r_mem[r_rd_ptr];
    end
  end

  assign count = r_count;

`ifndef SYNTHESIS
  a_no_overflow : assert property (
    @(posedge clock) disable iff (!reset_n || flush)
      !(push && !pop && (r_count == c_FULL))
  );
`endif

endmodule : vector_writeback_fifo

`default_nettype wire

// File: rtl/blk_6ef2cf.sv
// ============================================================
// Module  : blk_6ef2cf
// Brief   : Vector FP sqrt writeback buffer: issue tracking, credits, FIFO drain.
// Revision: 1.0
// ============================================================
`default_nettype none

module blk_6ef2cf
  import riscv_v_pkg::*;
  import dragonfang_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int LATENCY = 2
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 flush,
  input  logic                 issue_valid,
  input  logic [VD_ADDR_W-1:0] issue_vd_address,
  output logic                 issue_ready,
  input  logic [VLEN-1:0]      result,
  output logic                 wb_valid,
  input  logic                 wb_ready,
  output logic [VD_ADDR_W-1:0] wb_vd_address,
  output logic [VLEN-1:0]      wb_data
);

  localparam int c_CNT_W = $clog2(DEPTH) + 1;
  localparam int c_SUM_W = $clog2(DEPTH + LATENCY + 1) + 1;
  localparam logic [c_SUM_W-1:0] c_DEPTH_SUM = c_SUM_W'(DEPTH);

  logic [LATENCY-1:0]   r_dl_valid;
  logic [VD_ADDR_W-1:0] r_dl_addr [LATENCY];

  logic                 w_accept;
  logic                 w_push;
  logic                 w_pop;
  logic [c_SUM_W-1:0]   w_inflight;
  logic [c_SUM_W-1:0]   w_occupancy;
  logic [c_CNT_W-1:0]   w_fifo_count;
  logic                 w_head_valid;
  wb_entry_t            w_push_entry;
  wb_entry_t            w_head;

  assign w_accept = issue_valid && issue_ready;

  always_ff @(posedge clock) begin
    if (!reset_n || flush) begin
      r_dl_valid <= '0;
    end else begin
      r_dl_valid[0] <= w_accept;
      for (int k = 1; k < LATENCY; k++) begin
        r_dl_valid[k] <= r_dl_valid[k-1];
      end
    end
  end

  // Addresses are qualified by the valids, so they need no reset.
  always_ff @(posedge clock) begin
    r_dl_addr[0] <= issue_vd_address;
    for (int k = 1; k < LATENCY; k++) begin
      r_dl_addr[k] <= r_dl_addr[k-1];
    end
  end

  // Credits count both buffered and in-flight results, so the FIFO never overflows.
  always_comb begin
    w_inflight = '0;
    for (int k = 0; k < LATENCY; k++) begin
      w_inflight = w_inflight + c_SUM_W'(r_dl_valid[k]);
    end
    w_occupancy = c_SUM_W'(w_fifo_count) + w_inflight;
    issue_ready = (w_occupancy < c_DEPTH_SUM);
  end

  always_comb begin
    w_push                  = r_dl_valid[LATENCY-1];
    w_push_entry.vd_address = r_dl_addr[LATENCY-1];
    w_push_entry.data       = result;
    w_pop                   = w_head_valid && wb_ready;
  end

  vector_writeback_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset_n    (reset_n),
    .flush      (flush),
    .push       (w_push),
    .push_entry (w_push_entry),
    .pop        (w_pop),
    .head_valid (w_head_valid),
    .head       (w_head),
    .count      (w_fifo_count)
  );

  assign wb_valid      = w_head_valid;
  assign wb_vd_address = w_head.vd_address;
  assign wb_data       = w_head.data;

endmodule : blk_6ef2cf

`default_nettype wire

// File: tb/tb_blk_6ef2cf.sv
// ============================================================
// Module  : tb_blk_6ef2cf
// Brief   : Directed and random stimulus against a queue-based reference model.
// Revision: 1.0
// ============================================================
`default_nettype none

module tb_blk_6ef2cf;

  import riscv_v_pkg::*;
  import dragonfang_pkg::*;

  localparam int DEPTH   = 4;
  localparam int LATENCY = 2;

  logic                 clock;
  logic                 reset_n;
  logic                 flush;
  logic                 issue_valid;
  logic [VD_ADDR_W-1:0] issue_vd_address;
  logic                 issue_ready;
  logic [VLEN-1:0]      result;
  logic                 wb_valid;
  logic                 wb_ready;
  logic [VD_ADDR_W-1:0] wb_vd_address;
  logic [VLEN-1:0]      wb_data;

  blk_6ef2cf #(
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY)
  ) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .flush            (flush),
    .issue_valid      (issue_valid),
    .issue_vd_address (issue_vd_address),
    .issue_ready      (issue_ready),
    .result           (result),
    .wb_valid         (wb_valid),
    .wb_ready         (wb_ready),
    .wb_vd_address    (wb_vd_address),
    .wb_data          (wb_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [VD_ADDR_W-1:0] addr;
    logic [VLEN-1:0]      data;
    int                   due;
  } op_t;

  op_t inflight_q [$];
  op_t buffer_q   [$];
  int  cyc;
  int  n_checks;
  int  n_fail;

  task automatic check_val(input string tag, input logic [VLEN-1:0] got, input logic [VLEN-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [VLEN-1:0] rand_vec();
    logic [VLEN-1:0] v;
    for (int i = 0; i < VLEN / 32; i++) begin
      v[i*32 +: 32] = $urandom;
    end
    return v;
  endfunction

  // One clock cycle: check outputs against the model, drive inputs, advance the model.
  task automatic step(input bit iv, input logic [VD_ADDR_W-1:0] va, input logic [VLEN-1:0] vdata,
                      input bit wr, input bit fl, input bit rs);
    bit  exp_ready;
    bit  emerging;
    op_t op;
    exp_ready = (buffer_q.size() + inflight_q.size()) < DEPTH;
    emerging  = (inflight_q.size() > 0) && (inflight_q[0].due == cyc);
    check_val("issue_ready", VLEN'(issue_ready), VLEN'(exp_ready));
    check_val("wb_valid", VLEN'(wb_valid), VLEN'(buffer_q.size() != 0));
    if (buffer_q.size() != 0) begin
      check_val("wb_vd_address", VLEN'(wb_vd_address), VLEN'(buffer_q[0].addr));
      check_val("wb_data", wb_data, buffer_q[0].data);
    end else begin
      check_val("wb_vd_address_empty", VLEN'(wb_vd_address), '0);
      check_val("wb_data_empty", wb_data, '0);
    end

    issue_valid      = iv;
    issue_vd_address = va;
    wb_ready         = wr;
    flush            = fl;
    reset_n          = !rs;
    result           = emerging ? inflight_q[0].data : rand_vec();

    if (rs || fl) begin
      inflight_q.delete();
      buffer_q.delete();
    end else begin
      if (buffer_q.size() != 0 && wr) void'(buffer_q.pop_front());
      if (emerging) buffer_q.push_back(inflight_q.pop_front());
      if (iv && exp_ready) begin
        op.addr = va;
        op.data = vdata;
        op.due  = cyc + LATENCY;
        inflight_q.push_back(op);
      end
    end
    cyc++;
    @(negedge clock);
  endtask

  task automatic idle(input int n, input bit wr);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, wr, 1'b0, 1'b0);
  endtask

  initial begin
    logic [VLEN-1:0] one_f;
    one_f            = {(VLEN/32){32'h3F80_0000}};
    n_checks         = 0;
    n_fail           = 0;
    cyc              = 0;
    reset_n          = 1'b0;
    flush            = 1'b0;
    issue_valid      = 1'b0;
    issue_vd_address = '0;
    wb_ready         = 1'b0;
    result           = '0;
    repeat (2) @(negedge clock);

    // Reset state
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    idle(1, 1'b0);

    // Single op vd=5
    step(1'b1, 5'd5, one_f, 1'b1, 1'b0, 1'b0);
    idle(4, 1'b1);

    // Fill with wb_ready low, hold, then drain with one new issue per freed credit
    for (int v = 1; v <= 4; v++) step(1'b1, VD_ADDR_W'(v), rand_vec(), 1'b0, 1'b0, 1'b0);
    idle(10, 1'b0);
    for (int v = 5; v <= 12; v++) step(1'b1, VD_ADDR_W'(v), rand_vec(), 1'b1, 1'b0, 1'b0);
    idle(6, 1'b1);

    // Reset while the first result is emerging
    step(1'b1, 5'd20, rand_vec(), 1'b0, 1'b0, 1'b0);
    step(1'b1, 5'd21, rand_vec(), 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    idle(5, 1'b1);

    // Flush with two buffered and one in flight, then vd=9 writes back
    step(1'b1, 5'd2, rand_vec(), 1'b0, 1'b0, 1'b0);
    step(1'b1, 5'd3, rand_vec(), 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 5'd4, rand_vec(), 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 5'd9, rand_vec(), 1'b1, 1'b0, 1'b0);
    idle(5, 1'b1);

    // Pointer wrap: 11 ops with random wb_ready
    for (int n = 0; n < 11; ) begin
      bit rdy;
      rdy = (buffer_q.size() + inflight_q.size()) < DEPTH;
      step(rdy, VD_ADDR_W'(n + 10), rand_vec(), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      if (rdy) n++;
    end
    idle(10, 1'b1);

    // Random traffic with occasional flush and reset
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), VD_ADDR_W'($urandom), rand_vec(),
           1'($urandom_range(0, 2) != 0), ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 79) == 0));
    end
    idle(8, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_blk_6ef2cf

`default_nettype wire
